// File: rtl/sng_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sng_pkg
//  Description : Shared constants and state type for the stochastic number
//                generator (SNG) encoder and its LFSR.
//  Revision    : 1.0 - initial release
// ============================================================================
package sng_pkg;

    // Width of the pseudo-random source
    localparam int LFSR_WIDTH = 8;

    // Feedback taps for x^8+x^6+x^5+x^4+1 with a left shift (bits 7,5,4,3)
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAP_MASK = 8'hB8;

    // Non-zero fallback seed; an all-zero LFSR would lock up
    localparam logic [LFSR_WIDTH-1:0] DEFAULT_SEED = 8'h01;

    // Encoder control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        HOLD = 2'd2
    } sng_state_e;

endpackage
`default_nettype wire

// File: rtl/sng_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : sng_encoder_if
//  Description : Probability-in / bitstream-out handshake bundle for the
//                SNG encoder. The encoder connects through the slave modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sng_encoder_if #(
    parameter int STREAM_LEN = 8
);
    logic [7:0]            in_prob;
    logic                  in_valid;
    logic                  in_ready;
    logic [STREAM_LEN-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    // Producer of probabilities / consumer of bitstream words
    modport master (
        output in_prob,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid
    );

    // The encoder itself
    modport slave (
        input  in_prob,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid
    );
endinterface
`default_nettype wire

// File: rtl/sng_encoder_lfsr8.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr8
//  Description : 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, left shift.
//                Loads the seed on reset and steps only while en is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr8
    import sng_pkg::*;
(
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  en,
    input  wire logic [LFSR_WIDTH-1:0] seed,
    output logic      [LFSR_WIDTH-1:0] state
);

    logic [LFSR_WIDTH-1:0] state_q;
    logic [LFSR_WIDTH-1:0] state_d;
    logic [LFSR_WIDTH-1:0] seed_safe;

    // A zero seed would lock the register at zero, so substitute the default
    assign seed_safe = (seed == '0) ? DEFAULT_SEED : seed;

    // Next value: shift left, feedback is the parity of the tapped bits
    always_comb begin
        state_d = state_q;
        if (en) begin
            state_d = {state_q[LFSR_WIDTH-2:0], ^(state_q & LFSR_TAP_MASK)};
        end
    end

    // State register, reloaded from the seed on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= seed_safe;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/sng_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : sng_encoder
//  Description : Converts an 8-bit probability code p into a STREAM_LEN-bit
//                stochastic word whose ones-density approximates p/255.
//                Bit i = (lfsr <= p) for the i-th LFSR value of the word,
//                first comparison in the LSB. The LFSR runs only while
//                generating and carries on across words.
//  Revision    : 1.0 - initial release
// ============================================================================
module sng_encoder
    import sng_pkg::*;
#(
    parameter int               STREAM_LEN = 8,
    parameter logic [7:0]       SEED       = 8'h01
)(
    input  wire logic    clk,
    input  wire logic    rst,
    sng_encoder_if.slave bus
);

    // Index counter wide enough for STREAM_LEN up to 16
    localparam int              IDX_W    = 5;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STREAM_LEN - 1);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_GEN  = GEN;
    localparam logic [1:0] S_HOLD = HOLD;

    logic [1:0]            state_q, state_d;
    logic [IDX_W-1:0]      idx_q,   idx_d;
    logic [7:0]            p_q,     p_d;
    logic [STREAM_LEN-1:0] data_q,  data_d;

    logic [LFSR_WIDTH-1:0] lfsr_val;
    logic                  lfsr_en;
    logic                  cmp_bit;

    // The random source only advances while a word is being generated
    assign lfsr_en = (state_q == S_GEN);

    lfsr8 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (lfsr_en),
        .seed  (SEED),
        .state (lfsr_val)
    );

    // Unsigned compare; lfsr is never 0 so p=0 gives 0 and p=255 gives 1
    assign cmp_bit = (lfsr_val <= p_q);

    // FSM, bit index and word assembly
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        p_d     = p_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    p_d     = bus.in_prob;
                    idx_d   = '0;
                    data_d  = '0;
                    state_d = S_GEN;
                end
            end
            S_GEN: begin
                for (int i = 0; i < STREAM_LEN; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        data_d[i] = cmp_bit;
                    end
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registers; reset abandons any word in flight and restarts the sequence
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            p_q     <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            p_q     <= p_d;
            data_q  <= data_d;
        end
    end

    // Handshake outputs are pure state decodes; data comes straight from a register
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_HOLD);
    assign bus.out_data  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_sng_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sng_encoder
//  Description : Self-checking bench for sng_encoder (STREAM_LEN=8, SEED=01).
//                Expected words come from a table of the LFSR sequence built
//                from the polynomial and a running position in that sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sng_encoder;

    localparam int SL = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sng_encoder_if #(.STREAM_LEN(SL)) bus ();

    sng_encoder #(
        .STREAM_LEN (SL),
        .SEED       (8'h01)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // One full period of the pseudo-random sequence starting at the seed
    logic [7:0] seq [255];
    int         model_pos;

    function automatic void build_seq();
        logic [7:0] v;
        v = 8'h01;
        for (int i = 0; i < 255; i++) begin
            seq[i] = v;
            v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        end
    endfunction

    function automatic logic [SL-1:0] model_word(input logic [7:0] p, input int pos);
        logic [SL-1:0] w;
        w = '0;
        for (int i = 0; i < SL; i++) begin
            w[i] = (seq[(pos + i) % 255] <= p);
        end
        return w;
    endfunction

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_prob  = 8'h00;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        model_pos = 0;
    endtask

    // Issue one word, check latency, handshakes, data and stall behaviour.
    task automatic run_word(input logic [7:0] p, input int hold, input bit pulse,
                            output logic [SL-1:0] got);
        int            k;
        logic [SL-1:0] exp_w;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_before_accept: in_ready=%b required 1", bus.in_ready);
        end
        n_checks++;
        bus.in_prob   = p;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_prob  = 8'($urandom);
        k = 0;
        while (bus.out_valid !== 1'b1 && k < 40) begin
            n_checks++;
            if (bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL ready_in_gen: in_ready=%b required 0", bus.in_ready);
            end
            @(posedge clk);
            #1;
            k++;
        end
        n_checks++;
        if (k !== SL) begin
            n_fail++;
            $display("FAIL latency: out_valid after %0d cycles, required %0d", k, SL);
        end
        exp_w     = model_word(p, model_pos);
        model_pos = (model_pos + SL) % 255;
        got       = bus.out_data;
        n_checks++;
        if (got !== exp_w) begin
            n_fail++;
            $display("FAIL word p=%02h: out_data=%02h required %02h", p, got, exp_w);
        end
        for (int h = 0; h < hold; h++) begin
            if (pulse) begin
                bus.in_valid = 1'b1;
                bus.in_prob  = 8'($urandom);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== exp_w) begin
                n_fail++;
                $display("FAIL hold_stable: valid=%b ready=%b data=%02h required 1 0 %02h",
                         bus.out_valid, bus.in_ready, bus.out_data, exp_w);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release: valid=%b ready=%b required 0 1", bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_prob   = 8'h00;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b valid=%b data=%02h required 1 0 00",
                     bus.in_ready, bus.out_valid, bus.out_data);
        end
        rst       = 1'b0;
        model_pos = 0;
    endtask

    task automatic test_scenario1();
        logic [SL-1:0] w;
        do_reset();
        run_word(8'h10, 0, 1'b0, w);
        n_checks++;
        if (w !== 8'h0F) begin
            n_fail++;
            $display("FAIL s1_word: out_data=%02h required 0f", w);
        end
    endtask

    task automatic test_scenario2();
        logic [SL-1:0] w;
        do_reset();
        run_word(8'h80, 0, 1'b0, w);
        n_checks++;
        if (w !== 8'h7F) begin
            n_fail++;
            $display("FAIL s2_word1: out_data=%02h required 7f", w);
        end
        run_word(8'hFF, 1, 1'b0, w);
        n_checks++;
        if (w !== 8'hFF) begin
            n_fail++;
            $display("FAIL s2_word2: out_data=%02h required ff", w);
        end
    endtask

    task automatic test_boundaries();
        logic [SL-1:0] w;
        run_word(8'h00, 0, 1'b0, w);
        n_checks++;
        if (w !== 8'h00) begin
            n_fail++;
            $display("FAIL p_zero: out_data=%02h required 00", w);
        end
        run_word(8'hFF, 0, 1'b0, w);
        n_checks++;
        if (w !== 8'hFF) begin
            n_fail++;
            $display("FAIL p_full: out_data=%02h required ff", w);
        end
    endtask

    task automatic test_backpressure();
        logic [SL-1:0] w;
        run_word(8'h5A, 5, 1'b1, w);
    endtask

    task automatic test_reset_in_gen();
        logic [SL-1:0] w;
        do_reset();
        bus.in_prob  = 8'h10;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < SL + 2; c++) begin
            n_checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_abandon: valid=%b ready=%b required 0 1",
                         bus.out_valid, bus.in_ready);
            end
            @(posedge clk);
            #1;
        end
        model_pos = 0;
        run_word(8'h10, 0, 1'b0, w);
        n_checks++;
        if (w !== 8'h0F) begin
            n_fail++;
            $display("FAIL reseed_word: out_data=%02h required 0f", w);
        end
    endtask

    task automatic test_random();
        logic [SL-1:0] w;
        logic [7:0]    p;
        for (int n = 0; n < 30; n++) begin
            p = 8'($urandom);
            if (n % 10 == 3) p = 8'h00;
            if (n % 10 == 7) p = 8'hFF;
            run_word(p, int'($urandom_range(0, 3)), 1'($urandom), w);
        end
    endtask

    task automatic test_back_to_back();
        logic [SL-1:0] w;
        int            ones;
        ones = 0;
        do_reset();
        for (int n = 0; n < 255; n++) begin
            run_word(8'h80, 0, 1'b0, w);
            ones += $countones(w);
        end
        n_checks++;
        if (ones !== 1024) begin
            n_fail++;
            $display("FAIL density: ones=%0d required 1024", ones);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        build_seq();
        test_reset();
        test_scenario1();
        test_scenario2();
        test_boundaries();
        test_backpressure();
        test_reset_in_gen();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sng_encoder.md
SNG_ENCODER -- requirements
Module: sng_encoder

Interface
REQ-001 Parameter STREAM_LEN, default 8, is the number of stochastic bits per output word; legal range 1..16.
REQ-002 Parameter SEED, default 8'h01, is the LFSR reset value; a value of 0 SHALL be replaced by 8'h01.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port in_prob, input, 8 bits: probability code p; the target ones-density is p/255.
REQ-006 Port in_valid, input, 1 bit: in_prob is valid.
REQ-007 Port in_ready, output, 1 bit: the block accepts in_prob.
REQ-008 Port out_data, output, STREAM_LEN bits: the stochastic bitstream word, a popcount-compatible bit vector.
REQ-009 Port out_valid, output, 1 bit: out_data is valid.
REQ-010 Port out_ready, input, 1 bit: the consumer accepts out_data.

Function
REQ-011 States: IDLE, GEN, HOLD; the state after reset is IDLE.
REQ-012 IDLE: in_ready=1 and out_valid=0. On in_valid, latch in_prob, clear the bit index and out_data, and go to GEN.
REQ-013 GEN: in_ready=0 and out_valid=0. Each cycle, write out_data[idx] = (lfsr <= p) as an unsigned compare, advance the LFSR once, and increment idx.
REQ-014 When STREAM_LEN bits have been written, go to HOLD. out_valid SHALL rise exactly STREAM_LEN cycles after the accept edge.
REQ-015 HOLD: out_valid=1, in_ready=0. out_data and the latched p stay stable until out_valid&&out_ready; the next state is then IDLE.
REQ-016 Bit order: the first comparison goes to the LSB.
REQ-017 Minimum issue interval: STREAM_LEN+2 cycles per word. There is no in/out bypass in HOLD.
REQ-018 LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shift left, next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. Period 255, never 0.
REQ-019 The LFSR advances only in GEN. It is not reseeded between words; consecutive words continue the sequence.
REQ-020 Boundaries: p=0 SHALL yield all zeros and p=255 SHALL yield all ones, because lfsr is in 1..255.
REQ-021 in_valid while in_ready=0 is ignored; in_prob is not sampled.
REQ-022 out_ready while out_valid=0 has no effect.
REQ-023 All outputs SHALL be registered or decoded only from state; there are no combinational paths from input to output.

Reset
REQ-024 rst=1 at a clock edge forces: state=IDLE, lfsr=SEED, idx=0, p=0, out_data=0, out_valid=0. in_ready=1 from the first cycle after reset.
REQ-025 Reset in GEN or HOLD abandons the word. No partial out_valid pulse is produced, and the post-reset LFSR sequence restarts from SEED.

Structure
REQ-026 Package sng_pkg SHALL hold: LFSR_WIDTH=8, the tap mask 8'hB8 (bits 7,5,4,3), DEFAULT_SEED=8'h01, and the state enum {IDLE, GEN, HOLD}.
REQ-027 One sub-module, lfsr8, SHALL be used: inputs clk, rst, en, seed; output 8-bit state. sng_encoder instantiates it once.
REQ-028 The compare, bit index counter and FSM reside in sng_encoder.

Verification (STREAM_LEN=8, SEED=8'h01; the LFSR values for word 1 are 01,02,04,08,11,23,47,8E)
REQ-029 Scenario 1: reset, then in_prob=8'h10 accepted with out_ready=1 -> out_valid rises 8 cycles after accept, out_data=8'h0F, one-cycle out_valid.
REQ-030 Scenario 2: reset, then in_prob=8'h80 -> out_data=8'h7F. Then a second word with in_prob=8'hFF -> out_data=8'hFF, using continued LFSR values (1C...).
REQ-031 Scenario 3: in_prob=8'h00 -> out_data=8'h00. Then in_prob=8'hFF -> out_data=8'hFF.
REQ-032 Scenario 4: out_ready held 0 for 5 cycles in HOLD -> out_valid and out_data held stable, in_ready=0, and in_valid pulses ignored. Then out_ready=1 -> IDLE on the next cycle.
REQ-033 Scenario 5: rst asserted in the 4th GEN cycle of in_prob=8'h10 -> out_valid stays 0. A new in_prob=8'h10 then returns 8'h0F, confirming the reseed.
REQ-034 Scenario 6: 255 back-to-back words at in_prob=8'h80 -> the total ones count across all 2040 bits equals 128*8=1024 (exact, full LFSR periods).
